// File: rtl/ps2_host_tx_if.sv
// Command-side bundle of the PS/2 host transmitter.
// The master modport belongs to the producer of command bytes; the slave modport belongs to the transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       tx_done;
  logic       tx_error;
  logic [1:0] err_code;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, tx_done, tx_error, err_code
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, tx_done, tx_error, err_code
  );
endinterface

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, shift a byte plus odd parity
// on device clock falls, then check the device ACK. Drives open-collector enables only.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int BIT_TIMEOUT    = 100000
) (
  input  logic         clock,
  input  logic         reset,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe
);

  localparam int MAX_A = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
  localparam int MAX_C = (MAX_A > INHIBIT_CYCLES) ? MAX_A : INHIBIT_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);
  localparam logic [CW-1:0] INH_LAST   = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;

  state_t        state_q;
  logic          clkMeta_q, clkSync_q, clkPrev_q;
  logic          datMeta_q, datSync_q;
  logic [7:0]    data_q;
  logic          parity_q;
  logic [3:0]    bitCnt_q;
  logic [CW-1:0] cnt_q;
  logic          firstEdge_q, ackGood_q;
  logic          clkOe_q, datOe_q, done_q, error_q;
  logic [1:0]    errCode_q;

  logic          clkFall_d, timeout_d;
  logic [CW-1:0] limit_d;

  assign clkFall_d = clkPrev_q & ~clkSync_q;
  // The long start limit only applies until the device has produced its first clock fall.
  assign limit_d   = firstEdge_q ? BIT_LAST : START_LAST;
  assign timeout_d = (cnt_q == limit_d);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      clkMeta_q   <= 1'b1;
      clkSync_q   <= 1'b1;
      clkPrev_q   <= 1'b1;
      datMeta_q   <= 1'b1;
      datSync_q   <= 1'b1;
      data_q      <= 8'h00;
      parity_q    <= 1'b0;
      bitCnt_q    <= 4'd0;
      cnt_q       <= '0;
      firstEdge_q <= 1'b0;
      ackGood_q   <= 1'b0;
      clkOe_q     <= 1'b0;
      datOe_q     <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      errCode_q   <= 2'b00;
    end else begin
      clkMeta_q <= ps2_clk_in;
      clkSync_q <= clkMeta_q;
      clkPrev_q <= clkSync_q;
      datMeta_q <= ps2_dat_in;
      datSync_q <= datMeta_q;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx.tx_valid) begin
            data_q    <= tx.tx_data;
            parity_q  <= ~^tx.tx_data;
            errCode_q <= 2'b00;
            cnt_q     <= '0;
            clkOe_q   <= 1'b1;
            datOe_q   <= 1'b0;
            state_q   <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt_q == INH_LAST) begin
            datOe_q <= 1'b1;
            state_q <= REQ;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        REQ: begin
          clkOe_q     <= 1'b0;
          cnt_q       <= '0;
          bitCnt_q    <= 4'd0;
          firstEdge_q <= 1'b0;
          ackGood_q   <= 1'b0;
          state_q     <= SEND;
        end
        SEND: begin
          if (clkFall_d) begin
            cnt_q       <= '0;
            firstEdge_q <= 1'b1;
            bitCnt_q    <= bitCnt_q + 4'd1;
            if (bitCnt_q < 4'd8) begin
              datOe_q <= ~data_q[bitCnt_q[2:0]];
            end else if (bitCnt_q == 4'd8) begin
              datOe_q <= ~parity_q;
            end else begin
              datOe_q <= 1'b0;
              state_q <= ACK;
            end
          end else if (timeout_d) begin
            clkOe_q   <= 1'b0;
            datOe_q   <= 1'b0;
            error_q   <= 1'b1;
            errCode_q <= 2'b01;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ACK: begin
          if (clkFall_d) begin
            ackGood_q <= ~datSync_q;
            if (datSync_q) begin
              error_q   <= 1'b1;
              errCode_q <= 2'b10;
            end
            state_q <= WAIT_IDLE;
          end else if (timeout_d) begin
            clkOe_q   <= 1'b0;
            datOe_q   <= 1'b0;
            error_q   <= 1'b1;
            errCode_q <= 2'b01;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (clkSync_q && datSync_q) begin
            done_q  <= ackGood_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx.tx_ready = (state_q == IDLE);
  assign tx.busy     = (state_q != IDLE);
  assign tx.tx_done  = done_q;
  assign tx.tx_error = error_q;
  assign tx.err_code = errCode_q;
  assign ps2_clk_oe  = clkOe_q;
  assign ps2_dat_oe  = datOe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a behavioural PS/2 device clocks the frame out and
// records the bits; a monitor pops expected outcomes whenever tx_done or tx_error fires.
module tb_ps2_host_tx;

  localparam int INH   = 20;
  localparam int START = 400;
  localparam int BITTO = 100;

  // Outcome kinds held in the scoreboard.
  localparam int OUT_ACK     = 0;
  localparam int OUT_NOACK   = 1;
  localparam int OUT_SILENT  = 2;
  localparam int OUT_STOPPED = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic clkOe, datOe;
  logic devClk = 1'b1;
  logic devDat = 1'b1;
  logic pinClk, pinDat;

  ps2_host_tx_if txIf ();

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .START_TIMEOUT (START),
    .BIT_TIMEOUT   (BITTO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .tx        (txIf),
    .ps2_clk_in(pinClk),
    .ps2_dat_in(pinDat),
    .ps2_clk_oe(clkOe),
    .ps2_dat_oe(datOe)
  );

  // Open-collector bus: either side can pull a line low.
  assign pinClk = ~clkOe & devClk;
  assign pinDat = ~datOe & devDat;

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] data;
    int         outcome;
  } exp_t;

  exp_t       expQ[$];
  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         doneCount = 0;
  int         expDone = 0;
  logic [9:0] devFrame;
  int         devSamples = 0;
  int         devEdges = 0;
  int         lastFallCyc = 0;
  int         oeFallCyc = 0;
  int         clkOeRun = 0;
  bit         pendingReady = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    checks++;
    if (actual < lo || actual > hi) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
    end
  endtask

  // Reference frame as the device should see it: data LSB first, odd parity, stop bit.
  function automatic logic [9:0] modelFrame(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, (ones % 2 == 0), d};
  endfunction

  // Device side: waits for the start bit, then clocks at a 40-cycle period, sampling on rise.
  task automatic runDevice(input int mode, input int stopAfter);
    int guard;
    guard = 0;
    devSamples = 0;
    devEdges = 0;
    while (!(clkOe == 1'b0 && datOe == 1'b1) && guard < 400) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 400) begin
      checkOutput("request_seen", 0, 1);
      return;
    end
    if (mode == OUT_SILENT) return;
    repeat (10) @(negedge clock);
    for (int n = 1; n <= 11; n++) begin
      if (mode == OUT_STOPPED && n > stopAfter) break;
      if (n == 11 && mode == OUT_ACK) begin
        devDat = 1'b0;
        repeat (5) @(negedge clock);
      end
      devClk = 1'b0;
      lastFallCyc = cyc;
      devEdges++;
      repeat (20) @(negedge clock);
      devClk = 1'b1;
      if (n <= 10) begin
        devFrame[n-1] = pinDat;
        devSamples++;
      end
      if (n == 11) devDat = 1'b1;
      repeat (20) @(negedge clock);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] d, input int mode, input int stopAfter, input bit expectOut);
    int guard;
    exp_t e;
    guard = 0;
    while (!txIf.tx_ready && guard < 2000) begin
      @(negedge clock);
      guard++;
    end
    if (expectOut) begin
      e.data = d;
      e.outcome = mode;
      expQ.push_back(e);
      if (mode == OUT_ACK) expDone++;
    end
    txIf.tx_data  = d;
    txIf.tx_valid = 1'b1;
    @(negedge clock);
    txIf.tx_valid = 1'b0;
    txIf.tx_data  = 8'($urandom);
    runDevice(mode, stopAfter);
    guard = 0;
    while (txIf.busy && guard < 2000) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 2000) checkOutput("busy_released", 0, 1);
    repeat (5) @(negedge clock);
  endtask

  // Monitor: pops an expectation for every tx_done / tx_error pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        clkOeRun = 0;
        pendingReady = 0;
        continue;
      end
      if (clkOe) begin
        clkOeRun++;
      end else if (clkOeRun > 0) begin
        checkOutput("clk_oe_width", clkOeRun, INH + 1);
        clkOeRun = 0;
        oeFallCyc = cyc;
      end
      if (pendingReady) begin
        checkOutput("ready_after_error", int'(txIf.tx_ready), 1);
        pendingReady = 0;
      end
      if (txIf.tx_done || txIf.tx_error) begin
        checkOutput("done_error_exclusive", int'(txIf.tx_done && txIf.tx_error), 0);
        if (txIf.tx_done) doneCount++;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_output", 1, 0);
        end else begin
          e = expQ.pop_front();
          case (e.outcome)
            OUT_ACK, OUT_NOACK: begin
              checkOutput("tx_done", int'(txIf.tx_done), (e.outcome == OUT_ACK) ? 1 : 0);
              checkOutput("err_code", int'(txIf.err_code), (e.outcome == OUT_ACK) ? 0 : 2);
              checkOutput("device_bits", devSamples, 10);
              checkOutput("device_frame", int'(devFrame), int'(modelFrame(e.data)));
            end
            default: begin
              checkOutput("tx_error", int'(txIf.tx_error), 1);
              checkOutput("err_code", int'(txIf.err_code), 1);
              checkOutput("lines_released", int'({clkOe, datOe}), 0);
              if (e.outcome == OUT_SILENT)
                checkOutput("start_timeout_delay", cyc - oeFallCyc, START);
              else
                checkRange("bit_timeout_delay", cyc - lastFallCyc, BITTO, BITTO + 4);
              pendingReady = 1;
            end
          endcase
        end
      end
    end
  end

  initial begin
    int doneBefore, guard;
    txIf.tx_valid = 1'b0;
    txIf.tx_data  = 8'h00;
    repeat (3) @(negedge clock);
    checkOutput("reset_ready", int'(txIf.tx_ready), 1);
    checkOutput("reset_busy", int'(txIf.busy), 0);
    checkOutput("reset_oe", int'({clkOe, datOe}), 0);
    checkOutput("reset_pulses", int'({txIf.tx_done, txIf.tx_error}), 0);
    checkOutput("reset_err_code", int'(txIf.err_code), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    $display("[TB] directed: 0xED with ACK");
    applyStimulus(8'hED, OUT_ACK, 0, 1'b1);
    $display("[TB] directed: 0x01 without ACK");
    applyStimulus(8'h01, OUT_NOACK, 0, 1'b1);
    $display("[TB] directed: 0xFF, silent device");
    applyStimulus(8'hFF, OUT_SILENT, 0, 1'b1);
    $display("[TB] directed: device stops after 5 edges");
    applyStimulus(8'h5A, OUT_STOPPED, 5, 1'b1);

    $display("[TB] directed: reset during bit 4");
    devEdges = 0;
    fork
      applyStimulus(8'h3C, OUT_STOPPED, 4, 1'b0);
      begin
        guard = 0;
        while (devEdges < 4 && guard < 3000) begin
          @(negedge clock);
          guard++;
        end
        repeat (8) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midreset_oe", int'({clkOe, datOe}), 0);
        checkOutput("midreset_busy", int'(txIf.busy), 0);
        checkOutput("midreset_ready", int'(txIf.tx_ready), 1);
        reset = 1'b0;
      end
    join
    applyStimulus(8'h00, OUT_ACK, 0, 1'b1);

    $display("[TB] directed: request while busy is ignored");
    doneBefore = doneCount;
    fork
      applyStimulus(8'h55, OUT_ACK, 0, 1'b1);
      begin
        guard = 0;
        while (!txIf.busy && guard < 100) begin
          @(negedge clock);
          guard++;
        end
        repeat (30) @(negedge clock);
        txIf.tx_data  = 8'hAA;
        txIf.tx_valid = 1'b1;
        @(negedge clock);
        txIf.tx_valid = 1'b0;
      end
    join
    checkOutput("single_done", doneCount - doneBefore, 1);

    $display("[TB] randomized frames");
    for (int i = 0; i < 8; i++)
      applyStimulus(8'($urandom), int'($urandom_range(0, 1)), 0, 1'b1);
    applyStimulus(8'($urandom), OUT_STOPPED, int'($urandom_range(1, 10)), 1'b1);

    repeat (10) @(negedge clock);
    checkOutput("scoreboard_empty", expQ.size(), 0);
    checkOutput("done_total", doneCount, expDone);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
